// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, HI/LO move and status signals of the multiply/divide unit
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (
        output start, op, a, b, flush, mthi, mtlo, wdata,
        input  busy, done, div_zero, hi, lo
    );
    modport slave (
        input  start, op, a, b, flush, mthi, mtlo, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle MIPS HI/LO multiply/divide unit; define MULDIV_DIV_EN to build the divider
module muldiv_unit (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] opb;
    logic [63:0] acc;
    logic        neg_res;
    logic        is_div;
    logic        idle_like;
    logic        accept;
    logic        sgn;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] prod;
`ifdef MULDIV_DIV_EN
    logic        neg_rem;
    logic        dz;
    logic [32:0] trial;
    logic [63:0] div_next;
    logic [31:0] quot;
    logic [31:0] rem;
`endif

    // operand magnitudes, one shift-add / restoring shift-subtract step, and sign-corrected results
    always_comb begin
        idle_like = state == IDLE || state == DONE;
        accept    = bus.start && !bus.flush && idle_like;
        sgn       = !bus.op[0];
        abs_a     = (sgn && bus.a[31]) ? -bus.a : bus.a;
        abs_b     = (sgn && bus.b[31]) ? -bus.b : bus.b;
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        prod      = neg_res ? -acc : acc;
`ifdef MULDIV_DIV_EN
        trial     = acc[63:31] - {1'b0, opb};
        div_next  = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
        quot      = dz ? 32'hFFFF_FFFF : (neg_res ? -acc[31:0] : acc[31:0]);
        rem       = neg_rem ? -acc[63:32] : acc[63:32];
`endif
    end

    // control FSM, iteration datapath and architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            opb          <= '0;
            acc          <= '0;
            neg_res      <= 1'b0;
            is_div       <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem      <= 1'b0;
            dz           <= 1'b0;
`endif
        end else if (bus.flush) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            if (idle_like) begin
                state <= IDLE;
                if (bus.mthi) bus.hi <= bus.wdata;
                if (bus.mtlo) bus.lo <= bus.wdata;
            end
            if (accept) begin
                state    <= RUN;
                bus.busy <= 1'b1;
                cnt      <= '0;
                opb      <= abs_b;
                acc      <= {32'd0, abs_a};
                neg_res  <= sgn && (bus.a[31] ^ bus.b[31]);
                is_div   <= bus.op[1];
`ifdef MULDIV_DIV_EN
                neg_rem  <= sgn && bus.a[31];
                dz       <= bus.op[1] && bus.b == 32'd0;
`else
                if (bus.op[1]) begin
                    state    <= FIX;
                    bus.busy <= 1'b0;
                end
`endif
            end
            if (state == RUN) begin
                cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
                acc <= is_div ? div_next : mul_next;
`else
                acc <= mul_next;
`endif
                if (cnt == 6'd31) state <= FIX;
            end
            if (state == FIX) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
`ifdef MULDIV_DIV_EN
                bus.div_zero <= dz;
                bus.hi       <= is_div ? rem : prod[63:32];
                bus.lo       <= is_div ? quot : prod[31:0];
`else
                bus.div_zero <= is_div;
                if (!is_div) begin
                    bus.hi <= prod[63:32];
                    bus.lo <= prod[31:0];
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (expectations follow MULDIV_DIV_EN)
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    muldiv_unit_if bus();
    muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        busy;
        int          cyc;
    } res_t;

    res_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic signed [63:0] sa, sbv, p, q, m;
        r.dz = 1'b0; r.busy = 1'b1; r.cyc = 34; r.hi = '0; r.lo = '0;
        sa = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        p = '0; q = '0; m = '0;
        if (!op[1]) begin
            if (op == 2'b00) p = sa * sbv;
            else p = {32'd0, a} * {32'd0, b};
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
                r.lo = 32'hFFFF_FFFF; r.hi = a; r.dz = 1'b1;
            end else if (op == 2'b10) begin
                q = sa / sbv; m = sa % sbv;
                r.lo = q[31:0]; r.hi = m[31:0];
            end else begin
                r.lo = a / b; r.hi = a % b;
            end
`else
            r.hi = exp_hi; r.lo = exp_lo; r.dz = 1'b1; r.busy = 1'b0; r.cyc = 2;
`endif
        end
        return r;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r = model(op, a, b);
        sb.push_back(r);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        checks++;
        if (bus.busy !== r.busy) begin
            errors++;
            $display("FAIL busy_after_start op=%0d: got %b want %b", op, bus.busy, r.busy);
        end
    endtask

    task automatic wait_check(input string name, input bit chain, input int c0);
        res_t r;
        int cyc;
        cyc = c0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        r = sb.pop_front();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d edges, want 1", name, bus.done, cyc);
        end
        checks++;
        if (cyc != r.cyc) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, cyc, r.cyc);
        end
        checks++;
        if (bus.hi !== r.hi) begin
            errors++;
            $display("FAIL %s hi: got %h want %h", name, bus.hi, r.hi);
        end
        checks++;
        if (bus.lo !== r.lo) begin
            errors++;
            $display("FAIL %s lo: got %h want %h", name, bus.lo, r.lo);
        end
        checks++;
        if (bus.div_zero !== r.dz) begin
            errors++;
            $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, r.dz);
        end
        exp_hi = r.hi;
        exp_lo = r.lo;
        if (!chain) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: got %b want 0", name, bus.done);
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h busy=%b done=%b div_zero=%b, want all zero",
                     name, bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_mult();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_check("multu_max", 0, 1);
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);         wait_check("mult_neg3x7", 0, 1);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000); wait_check("mult_minxmin", 0, 1);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_check("mult_m1xm1", 0, 1);
        for (int i = 0; i < 4; i++) begin
            issue(2'($urandom_range(0, 1)), $urandom, $urandom);
            wait_check("mult_rand", 0, 1);
        end
    endtask

    task automatic test_div();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_check("div_m7by2", 0, 1);
        issue(2'b11, 32'd5, 32'd0);                 wait_check("divu_by0", 0, 1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_check("div_overflow", 0, 1);
        issue(2'b10, 32'hFFFF_FFF7, 32'd0);         wait_check("div_neg_by0", 0, 1);
        issue(2'b11, 32'd100, 32'd7);               wait_check("divu_100by7", 0, 1);
        for (int i = 0; i < 3; i++) begin
            issue(2'($urandom_range(2, 3)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            wait_check("div_rand", 0, 1);
        end
    endtask

    task automatic test_ignore();
        issue(2'b01, 32'd6, 32'd7);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd99; bus.b = 32'd99;
        repeat (20) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_check("start_ignored", 0, 21);
    endtask

    task automatic test_flush();
        bool_seen: begin end
        bus.mthi = 1'b1; bus.wdata = 32'hAAAA_0001;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h5555_0002;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        exp_hi = 32'hAAAA_0001; exp_lo = 32'h5555_0002;
        checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL mt_idle: hi=%h lo=%h want %h %h", bus.hi, bus.lo, exp_hi, exp_lo);
        end
        issue(2'b01, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        void'(sb.pop_front());
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: busy=%b done=%b div_zero=%b want 0 0 0", bus.busy, bus.done, bus.div_zero);
        end
        checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL flush_hilo: hi=%h lo=%h want %h %h", bus.hi, bus.lo, exp_hi, exp_lo);
        end
        begin
            bit seen;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL flush_no_done: activity seen after flush, want none");
            end
        end
    endtask

    task automatic test_mt();
        issue(2'b01, 32'd2, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        bus.mtlo = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        checks++;
        if (bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL mtlo_busy: got %h want %h", bus.lo, exp_lo);
        end
        bus.mthi = 1'b1; bus.wdata = 32'h4321;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        checks++;
        if (bus.hi !== exp_hi) begin
            errors++;
            $display("FAIL mthi_busy: got %h want %h", bus.hi, exp_hi);
        end
        wait_check("mt_busy_op", 0, 8);
        bus.mtlo = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        exp_lo = 32'h1234;
        checks++;
        if (bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL mtlo_idle: got %h want %h", bus.lo, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0100);
        wait_check("b2b_first", 1, 1);
        bus.mtlo = 1'b1; bus.wdata = 32'hCAFE;
        issue(2'b00, 32'hFFFF_FFFB, 32'd9);
        checks++;
        if (bus.lo !== 32'hCAFE) begin
            errors++;
            $display("FAIL mtlo_with_start: got %h want %h", bus.lo, 32'hCAFE);
        end
        wait_check("b2b_second", 0, 1);
    endtask

    task automatic test_async_reset();
        issue(2'b00, 32'h0001_2345, 32'hFFFF_FFFD);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        void'(sb.pop_front());
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(2'b01, 32'd7, 32'd6);
        wait_check("after_reset", 0, 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        test_reset();
        test_mult();
        test_div();
        test_ignore();
        test_flush();
        test_mt();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports as below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 start  in  1  request a mul/div; accepted only in IDLE or DONE.
REQ-005 op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with an accepted start.
REQ-006 a, b  in  32 each  rs and rt operands; sampled with an accepted start.
REQ-007 flush  in  1  cancels any in-flight operation (exception/branch squash).
REQ-008 mthi, mtlo  in  1 each  write wdata to HI or LO respectively.
REQ-009 wdata  in  32  data for mthi/mtlo.
REQ-010 busy  out  1  high in RUN and FIX.
REQ-011 done  out  1  one-cycle pulse in DONE.
REQ-012 hi, lo  out  32 each  architectural HI/LO registers, registered outputs.
REQ-013 div_zero  out  1  valid with done; high if the completed op was a divide with b==0.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-015 IDLE/DONE + start SHALL latch op, |a| and |b| (signed ops) or a and b (unsigned ops) plus result-sign bits, clear a 6-bit counter and go to RUN.
REQ-016 RUN SHALL perform one iteration per cycle for 32 cycles: shift-add for multiply, restoring shift-subtract for divide; counter==31 -> FIX.
REQ-017 FIX SHALL apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend sign; then -> DONE.
REQ-018 On the FIX->DONE edge HI/LO SHALL load the result: multiply HI=product[63:32], LO=product[31:0]; divide LO=quotient, HI=remainder.
REQ-019 Latency SHALL be fixed: start accepted at edge N, hi/lo updated and done=1 after edge N+33, done low after edge N+34 unless a new start occurs.
REQ-020 DONE with no start SHALL return to IDLE; DONE with start SHALL go directly to RUN (back-to-back ops).
REQ-021 start while busy SHALL be ignored, and the pipeline SHALL stall.
REQ-022 Divide by zero SHALL yield LO=32'hFFFF_FFFF, HI=a (original, unsigned view) and div_zero=1 in DONE, irrespective of signedness.
REQ-023 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield LO=32'h8000_0000, HI=0 with no error indication.
REQ-024 mthi/mtlo SHALL write on the edge when not busy; while busy they SHALL be ignored.
REQ-025 mthi/mtlo together with an accepted start SHALL write immediately, and the later result SHALL overwrite both HI and LO.
REQ-026 flush SHALL force IDLE on the next edge from any state, leaving HI/LO unchanged and done and div_zero low; flush with start SHALL discard the start.
REQ-027 Internal datapath SHALL be 64-bit (accumulator/remainder) with 32-bit operand registers; no carry beyond bit 63 is retained.

Reset
REQ-028 Reset SHALL force IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0, asynchronously and independent of clk.
REQ-029 Reset mid-operation SHALL abandon the operation, and the first start after deassertion SHALL behave as from IDLE.

Configuration
REQ-030 Macro MULDIV_DIV_EN defined SHALL compile in the divider and the behaviour of REQ-016 to REQ-023.
REQ-031 Without MULDIV_DIV_EN, DIV/DIVU starts SHALL complete in one cycle (done after edge N+1, busy never high), leave HI/LO unchanged and assert div_zero with done as an unimplemented-op flag, and no divider logic SHALL be synthesised.

Verification
REQ-032 MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> after 34 edges HI=32'hFFFF_FFFE, LO=32'h0000_0001, done one cycle.
REQ-033 MULT a=-3 (32'hFFFF_FFFD), b=7 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
REQ-034 DIV a=-7, b=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU a=5, b=0 -> LO=32'hFFFF_FFFF, HI=5, div_zero=1.
REQ-035 MULTU 3x4 started, flush at RUN cycle 10 -> IDLE next edge, HI/LO keep prior values, no done; start held while busy -> ignored.
REQ-036 mtlo wdata=32'h1234 while busy -> LO unchanged; same in IDLE -> LO=32'h1234; start in DONE cycle -> next op completes 34 edges later.
REQ-037 Reset asserted asynchronously mid-RUN -> outputs zero immediately, without a clock edge.
